// File: rtl/iob_counter_updown_mod.sv
// Up/down modulo counter with programmable step, runtime upper bound, parallel load and
// wrap/saturate handling at the bounds; raises a terminal-count pulse and sticky overflow.
module iob_counter_updown_mod #(
   parameter int unsigned       DATA_W   = 32,
   parameter int unsigned       STEP_W   = 8,
   parameter logic [DATA_W-1:0] RST_VAL  = '0,
   parameter bit                SATURATE = 1'b0
) (
   input  logic              clk_i,
   input  logic              arst_i,
   input  logic              rst_i,
   input  logic              en_i,
   input  logic              dir_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic [DATA_W-1:0] max_i,
   input  logic              ld_i,
   input  logic [DATA_W-1:0] ld_val_i,
   input  logic              clr_ovf_i,
   output logic [DATA_W-1:0] data_o,
   output logic              tc_o,
   output logic              ovf_o
);

   logic [DATA_W-1:0] r_data;
   logic              r_tc;
   logic              r_ovf;

   logic [DATA_W-1:0] w_data_d;
   logic              w_tc_d;
   logic              w_ovf_d;
   logic [DATA_W-1:0] w_step;
   logic [DATA_W:0]   w_sum;
   logic              w_up_ev;
   logic              w_dn_ev;

   assign w_step  = DATA_W'(step_i);
   // One extra bit so a sum past the counter width still compares above max_i
   assign w_sum   = {1'b0, r_data} + {1'b0, w_step};
   assign w_up_ev = w_sum > {1'b0, max_i};
   assign w_dn_ev = w_step > r_data;

   always_comb begin
      w_data_d = r_data;
      w_tc_d   = 1'b0;
      w_ovf_d  = r_ovf & ~clr_ovf_i;
      if (rst_i) begin
         w_data_d = RST_VAL;
         w_ovf_d  = 1'b0;
      end else if (ld_i) begin
         w_data_d = ld_val_i;
      end else if (en_i && (w_step != '0)) begin
         if (!dir_i) begin
            if (w_up_ev) begin
               w_tc_d   = 1'b1;
               w_data_d = SATURATE ? max_i : '0;
            end else begin
               w_data_d = w_sum[DATA_W-1:0];
            end
         end else begin
            if (w_dn_ev) begin
               w_tc_d   = 1'b1;
               w_data_d = SATURATE ? '0 : max_i;
            end else begin
               w_data_d = r_data - w_step;
            end
         end
      end
      // A new event outranks a same-cycle clear
      if (w_tc_d) begin
         w_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_data <= RST_VAL;
         r_tc   <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         r_data <= w_data_d;
         r_tc   <= w_tc_d;
         r_ovf  <= w_ovf_d;
      end
   end

   assign data_o = r_data;
   assign tc_o   = r_tc;
   assign ovf_o  = r_ovf;

endmodule
